sdram_pll_reset_sequencer: RTL and testbench
============================================

# sdram_pll_reset_sequencer

Reset sequencer downstream of the SDRAM PLL: consumes the PLL `locked` flag, drives the PLL reset, and releases the SDRAM-controller reset and then the system reset only after lock has been stable for a programmable time. It retries the PLL on lock timeout and forces the whole chain back into reset on any lock loss. It runs on the 100 MHz reference clock; consumers in the 143 MHz domain resynchronise its reset outputs locally.

## Interface
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset pulse (≥2).
- `LOCK_STABLE_CYCLES`, 1000: consecutive synchronised-lock cycles required before the SDRAM reset is released (≥2).
- `SDRAM_TO_SYS_CYCLES`, 32: cycles between SDRAM reset release and system reset release (≥2).
- `LOCK_TIMEOUT_CYCLES`, 100000: maximum wait for lock before the PLL is reset again (≥2).
- `CNT_W`, 17: width of the shared down-counter; must hold the largest parameter minus 1.
- `clk`  in  1: reference clock, 100 MHz.
- `reset_n`  in  1: synchronous, active-low reset.
- `pll_locked`  in  1: asynchronous PLL lock flag.
- `pll_rst`  out  1: active-high PLL reset.
- `sdram_reset_n`  out  1: active-low SDRAM controller reset.
- `sys_reset_n`  out  1: active-low system reset.
- `ready`  out  1: high only in RUN.
- `lock_loss_count`  out  8: number of lock losses after release; saturates at 255.
- `state`  out  3: current state encoding, for debug.

## Operation
- `pll_locked` passes through a 2-flop synchroniser to give `locked_s`; only `locked_s` is used.
- State encodings: PLL_RESET=0, WAIT_LOCK=1, STABLE=2, RELEASE_SDRAM=3, RUN=4. Codes 5–7 go to PLL_RESET on the next edge.
- The counter clears on every state entry. In each cycle it either matches its terminal value N−1 and the state transitions, or it increments.
- **PLL_RESET:** `pll_rst`=1. At `PLL_RST_CYCLES`−1 → WAIT_LOCK.
- **WAIT_LOCK:** `pll_rst`=0.
  - If `locked_s`=1 → STABLE.
  - Else, at `LOCK_TIMEOUT_CYCLES`−1 → PLL_RESET. This branch is present only with the configuration macro.
- **STABLE:**
  - If `locked_s`=0 → WAIT_LOCK. This is not counted as a loss.
  - Else, at `LOCK_STABLE_CYCLES`−1 → RELEASE_SDRAM.
- **RELEASE_SDRAM:** `sdram_reset_n`=1.
  - If `locked_s`=0 → PLL_RESET and `lock_loss_count` increments.
  - Else, at `SDRAM_TO_SYS_CYCLES`−1 → RUN.
- **RUN:** `sdram_reset_n`=`sys_reset_n`=`ready`=1.
  - If `locked_s`=0 → PLL_RESET and `lock_loss_count` increments.
- Priority: lock loss takes precedence over counter terminal in the same cycle.
- `lock_loss_count` increments by 1 per loss event and holds at 255.
- All outputs are registered and decoded from the next state, so each output changes on the same edge as the state.

## Timing
- Reset values while `reset_n`=0, applied at each edge:
  - `state`=PLL_RESET, counter=0, synchroniser=0.
  - `pll_rst`=1, `sdram_reset_n`=0, `sys_reset_n`=0, `ready`=0, `lock_loss_count`=0.
- Reset asserted mid-operation behaves identically, from any state.
- Edge numbering: edge 1 is the first rising edge with `reset_n`=1.
- With `locked_s` already high:
  - `pll_rst` falls at edge `PLL_RST_CYCLES`.
  - STABLE is entered at edge `PLL_RST_CYCLES`+1.
  - `sdram_reset_n` rises at edge `PLL_RST_CYCLES`+1+`LOCK_STABLE_CYCLES`.
  - `sys_reset_n`/`ready` rise `SDRAM_TO_SYS_CYCLES` edges after `sdram_reset_n`.
- Lock-loss latency: 2 edges of synchroniser, then 1 edge to PLL_RESET. All resets assert at that third edge after `pll_locked` falls.
- Release order is always `sdram_reset_n` strictly before `sys_reset_n`. Assertion on loss is simultaneous.

## Configuration
- Macro: `SDRAM_PLL_RSTSEQ_TIMEOUT_EN`.
- **Defined:** the WAIT_LOCK timeout is active. After `LOCK_TIMEOUT_CYCLES` cycles in WAIT_LOCK without lock, the block re-enters PLL_RESET and re-pulses `pll_rst`. This repeats indefinitely.
- **Undefined:** WAIT_LOCK waits for lock forever. `LOCK_TIMEOUT_CYCLES` is ignored.

## Test plan
Bench parameters: `PLL_RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `SDRAM_TO_SYS_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=50.

- **Clean bring-up:** `pll_locked`=1 throughout, release reset → `pll_rst` low at edge 4, `sdram_reset_n` high at edge 13, `sys_reset_n`/`ready` high at edge 17, `state`=4, `lock_loss_count`=0.
- **Lock glitch in STABLE:** drop `pll_locked` for one cycle around edge 8 → `state` returns to 1 and `lock_loss_count` stays 0. `sdram_reset_n` then rises 9 edges after `locked_s` returns high.
- **Loss in RUN:** after `ready`, drop `pll_locked` → within 3 edges `ready`=`sys_reset_n`=`sdram_reset_n`=0 and `pll_rst`=1 for 4 cycles. `lock_loss_count`=1. Full re-release follows once lock returns.
- **Timeout retry:** `pll_locked` held 0.
  - Macro defined → `pll_rst` pulses high for 4 cycles every 54 cycles.
  - Macro undefined → `pll_rst` stays 0 after edge 4 and `state` stays 1.
- **Saturation:** 300 lock-loss events in RUN → `lock_loss_count`=255, with no wrap.
- **Mid-run reset:** assert `reset_n` in RUN → all outputs return to their reset values at the next edge. On `reset_n` release, `lock_loss_count`=0 and the bring-up timing repeats exactly.

Source files
------------

// File: rtl/sdram_pll_reset_sequencer.sv
// Reset sequencer for the SDRAM PLL: pulses pll_rst, waits for stable lock, then releases
// the SDRAM reset followed by the system reset. Define SDRAM_PLL_RSTSEQ_TIMEOUT_EN to retry the PLL on lock timeout.
module sdram_pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1000,
    parameter int unsigned SDRAM_TO_SYS_CYCLES = 32,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W               = 17
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sdram_reset_n,
    output logic       sys_reset_n,
    output logic       ready,
    output logic [7:0] lock_loss_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_PLL_RESET     = 3'd0,
        ST_WAIT_LOCK     = 3'd1,
        ST_STABLE        = 3'd2,
        ST_RELEASE_SDRAM = 3'd3,
        ST_RUN           = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] PLL_RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SDRAM_LAST    = CNT_W'(SDRAM_TO_SYS_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, locked_s_q;
    logic             loss_d;
    logic             pll_rst_q, sdram_reset_n_q, sys_reset_n_q, ready_q;
    logic [7:0]       loss_cnt_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        loss_d  = 1'b0;
        unique case (state_q)
            ST_PLL_RESET: begin
                if (cnt_q == PLL_RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (locked_s_q) begin
                    state_d = ST_STABLE;
                end
`ifdef SDRAM_PLL_RSTSEQ_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_PLL_RESET;
                end
`else
                // Without the timeout the counter parks instead of wrapping.
                else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = cnt_q;
                end
`endif
            end
            ST_STABLE: begin
                if (!locked_s_q)                state_d = ST_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST)  state_d = ST_RELEASE_SDRAM;
            end
            ST_RELEASE_SDRAM: begin
                if (!locked_s_q) begin
                    state_d = ST_PLL_RESET;
                    loss_d  = 1'b1;
                end else if (cnt_q == SDRAM_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!locked_s_q) begin
                    state_d = ST_PLL_RESET;
                    loss_d  = 1'b1;
                end
            end
            default: state_d = ST_PLL_RESET;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are decoded from state_d so they move on the same edge as the state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_n) begin
            state_q         <= ST_PLL_RESET;
            cnt_q           <= '0;
            sync1_q         <= 1'b0;
            locked_s_q      <= 1'b0;
            pll_rst_q       <= 1'b1;
            sdram_reset_n_q <= 1'b0;
            sys_reset_n_q   <= 1'b0;
            ready_q         <= 1'b0;
            loss_cnt_q      <= 8'd0;
        end else begin
            sync1_q         <= pll_locked;
            locked_s_q      <= sync1_q;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pll_rst_q       <= (state_d == ST_PLL_RESET);
            sdram_reset_n_q <= (state_d == ST_RELEASE_SDRAM) || (state_d == ST_RUN);
            sys_reset_n_q   <= (state_d == ST_RUN);
            ready_q         <= (state_d == ST_RUN);
            if (loss_d && (loss_cnt_q != 8'hFF)) loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign pll_rst         = pll_rst_q;
    assign sdram_reset_n   = sdram_reset_n_q;
    assign sys_reset_n     = sys_reset_n_q;
    assign ready           = ready_q;
    assign lock_loss_count = loss_cnt_q;
    assign state           = state_q;

endmodule

// File: tb/tb_sdram_pll_reset_sequencer.sv
// Scoreboard bench for sdram_pll_reset_sequencer: a phase/age reference model predicts every
// cycle's outputs into a queue; a monitor pops and compares after each rising edge.
module tb_sdram_pll_reset_sequencer;

    localparam int PLL_RST_C = 4;
    localparam int STABLE_C  = 8;
    localparam int S2S_C     = 4;
    localparam int TIMEOUT_C = 50;
`ifdef SDRAM_PLL_RSTSEQ_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    typedef struct packed {
        logic       pll_rst;
        logic       sdram_n;
        logic       sys_n;
        logic       rdy;
        logic [7:0] cnt;
        logic [2:0] st;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b1;
    logic       pll_rst, sdram_reset_n, sys_reset_n, ready;
    logic [7:0] lock_loss_count;
    logic [2:0] state;

    sdram_pll_reset_sequencer #(
        .PLL_RST_CYCLES     (PLL_RST_C),
        .LOCK_STABLE_CYCLES (STABLE_C),
        .SDRAM_TO_SYS_CYCLES(S2S_C),
        .LOCK_TIMEOUT_CYCLES(TIMEOUT_C),
        .CNT_W              (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pll_locked     (pll_locked),
        .pll_rst        (pll_rst),
        .sdram_reset_n  (sdram_reset_n),
        .sys_reset_n    (sys_reset_n),
        .ready          (ready),
        .lock_loss_count(lock_loss_count),
        .state          (state)
    );

    always #5 clk = ~clk;

    outs_t exp_q[$];
    int    id_q[$];
    int    edge_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    drv_edge = 0;

    // Reference model: phase code, cycles spent in the phase, two-stage lock delay line.
    int m_ph = 0, m_age = 0, m_loss = 0;
    bit m_s1 = 1'b0, m_ls = 1'b0;

    function automatic int dur_of(input int p);
        case (p)
            0:       return PLL_RST_C;
            1:       return TIMEOUT_ON ? TIMEOUT_C : 0;
            2:       return STABLE_C;
            3:       return S2S_C;
            default: return 0;
        endcase
    endfunction

    function automatic int after_time(input int p);
        case (p)
            0:       return 1;
            1:       return 0;
            2:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic model_step(input bit rst_n, input bit lock);
        int nph;
        bit seen;
        if (!rst_n) begin
            m_ph = 0; m_age = 0; m_loss = 0; m_s1 = 1'b0; m_ls = 1'b0;
        end else begin
            seen = m_ls;
            m_ls = m_s1;
            m_s1 = lock;
            nph  = m_ph;
            if (m_ph >= 2 && !seen) begin
                nph = (m_ph == 2) ? 1 : 0;
                if (m_ph >= 3 && m_loss < 255) m_loss++;
            end else if (m_ph == 1 && seen) begin
                nph = 2;
            end else if (dur_of(m_ph) != 0 && m_age + 1 == dur_of(m_ph)) begin
                nph = after_time(m_ph);
            end
            m_age = (nph == m_ph) ? m_age + 1 : 0;
            m_ph  = nph;
        end
    endtask

    function automatic outs_t expect_outs();
        outs_t o;
        o.pll_rst = (m_ph == 0);
        o.sdram_n = (m_ph >= 3);
        o.sys_n   = (m_ph == 4);
        o.rdy     = (m_ph == 4);
        o.cnt     = m_loss[7:0];
        o.st      = m_ph[2:0];
        return o;
    endfunction

    function automatic string scen_name(input int id);
        case (id)
            0:       return "reset";
            1:       return "bringup";
            2:       return "glitch_stable";
            3:       return "loss_run";
            4:       return "timeout";
            5:       return "saturation";
            6:       return "midrun_reset";
            default: return "random";
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock of stimulus: drive at the falling edge and queue the model's prediction.
    task automatic cycle(input bit rst_n, input bit lock, input int id);
        @(negedge clk);
        reset_n    = rst_n;
        pll_locked = lock;
        model_step(rst_n, lock);
        if (!rst_n) drv_edge = 0;
        else        drv_edge++;
        exp_q.push_back(expect_outs());
        id_q.push_back(id);
        edge_q.push_back(drv_edge);
    endtask

    task automatic run(input int n, input bit lock, input int id);
        for (int i = 0; i < n; i++) cycle(1'b1, lock, id);
    endtask

    // Monitor: edge-of-event recorders plus the scoreboard compare.
    int mon_edge = 0;
    int rec_pll_fall = -1, rec_sdram_rise = -1, rec_sys_rise = -1, rec_ready_fall = -1;
    int rec_rst_rises = 0;
    bit prev_pll_rst = 1'b1, prev_ready = 1'b0;

    initial begin
        outs_t e, a;
        int    id, ed;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                mon_edge = 0; rec_pll_fall = -1; rec_sdram_rise = -1; rec_sys_rise = -1;
                rec_ready_fall = -1; rec_rst_rises = 0;
            end else begin
                mon_edge++;
                if (rec_pll_fall < 0 && !pll_rst)             rec_pll_fall   = mon_edge;
                if (rec_sdram_rise < 0 && sdram_reset_n)      rec_sdram_rise = mon_edge;
                if (rec_sys_rise < 0 && sys_reset_n)          rec_sys_rise   = mon_edge;
                if (rec_ready_fall < 0 && prev_ready && !ready) rec_ready_fall = mon_edge;
                if (!prev_pll_rst && pll_rst)                 rec_rst_rises++;
            end
            prev_pll_rst = pll_rst;
            prev_ready   = ready;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                ed = edge_q.pop_front();
                a  = {pll_rst, sdram_reset_n, sys_reset_n, ready, lock_loss_count, state};
                n_cmp++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard %s edge %0d: got rst=%b sdram_n=%b sys_n=%b rdy=%b cnt=%0d st=%0d, expected rst=%b sdram_n=%b sys_n=%b rdy=%b cnt=%0d st=%0d",
                             scen_name(id), ed, a.pll_rst, a.sdram_n, a.sys_n, a.rdy, a.cnt, a.st,
                             e.pll_rst, e.sdram_n, e.sys_n, e.rdy, e.cnt, e.st);
                end
            end
        end
    end

    initial begin
        int  hold;
        int  guard;
        bit  lk;
        bit  rst;

        // Clean bring-up with lock present throughout.
        repeat (3) cycle(1'b0, 1'b1, 0);
        run(25, 1'b1, 1);
        check("bringup_pll_rst_fall_edge", rec_pll_fall, 4);
        check("bringup_sdram_rise_edge", rec_sdram_rise, 13);
        check("bringup_sys_rise_edge", rec_sys_rise, 17);
        check("bringup_state", int'(state), 4);
        check("bringup_loss_count", int'(lock_loss_count), 0);

        // One-cycle lock glitch while in STABLE.
        repeat (2) cycle(1'b0, 1'b1, 0);
        run(7, 1'b1, 2);
        cycle(1'b1, 1'b0, 2);
        run(22, 1'b1, 2);
        check("glitch_sdram_rise_edge", rec_sdram_rise, 19);
        check("glitch_loss_count", int'(lock_loss_count), 0);

        // Lock loss in RUN: lock low for edges 20..25.
        repeat (2) cycle(1'b0, 1'b1, 0);
        run(19, 1'b1, 3);
        run(6, 1'b0, 3);
        run(35, 1'b1, 3);
        check("loss_run_ready_fall_edge", rec_ready_fall, 22);
        check("loss_run_loss_count", int'(lock_loss_count), 1);
        check("loss_run_rerelease_state", int'(state), 4);

        // No lock at all: timeout retry or endless wait depending on the build.
        repeat (2) cycle(1'b0, 1'b0, 0);
        run(120, 1'b0, 4);
        check("timeout_pll_rst_pulses", rec_rst_rises, TIMEOUT_ON ? 2 : 0);
        check("timeout_state", int'(state), 1);

        // 300 loss events in RUN; the counter must hold at 255.
        repeat (2) cycle(1'b0, 1'b1, 0);
        for (int ev = 0; ev < 300; ev++) begin
            guard = 0;
            while (m_ph != 4 && guard < 100) begin
                cycle(1'b1, 1'b1, 5);
                guard++;
            end
            if (guard >= 100) begin
                check("saturation_reach_run_timeout", guard, 0);
                break;
            end
            cycle(1'b1, 1'b0, 5);
            run(3, 1'b1, 5);
        end
        run(4, 1'b1, 5);
        check("saturation_loss_count", int'(lock_loss_count), 255);

        // Reset asserted in RUN, then a full re-bring-up.
        run(30, 1'b1, 6);
        check("midrun_pre_reset_ready", int'(ready), 1);
        repeat (2) cycle(1'b0, 1'b1, 6);
        check("midrun_reset_loss_count", int'(lock_loss_count), 0);
        check("midrun_reset_pll_rst", int'(pll_rst), 1);
        run(25, 1'b1, 6);
        check("midrun_pll_rst_fall_edge", rec_pll_fall, 4);
        check("midrun_sdram_rise_edge", rec_sdram_rise, 13);
        check("midrun_sys_rise_edge", rec_sys_rise, 17);

        // Random lock run-lengths with occasional resets.
        hold = 0;
        lk   = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                lk   = ($urandom_range(0, 3) != 0);
                hold = lk ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 6));
            end
            hold--;
            rst = ($urandom_range(0, 299) != 0);
            cycle(rst, lk, 7);
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
